regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8x8 register file (R0 hardwired to zero)
//  between NUM_REQ writeback sources (e.g. ALU result, memory load, immediate
//  load) using round-robin arbitration with a valid/ready handshake.
//  The granted write is registered once and driven onto WriteReg/WriteData/RegWrite.
//  Sits between the execute/writeback sources and the register file write port.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  DATA_W   8  write data width
//  ADDR_W   3  register index width (8 registers)
// PORTS
//  clk        in   1                single clock, rising edge
//  rst        in   1                asynchronous, active-high reset
//  req_valid  in   NUM_REQ          requester i has a write pending
//  req_reg    in   NUM_REQ*ADDR_W   target reg, requester i at [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W   write data, requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          one-hot accept; handshake when valid&ready
//  stall      in   1                block new grants (write port unavailable)
//  WriteReg   out  ADDR_W           register index to register file
//  WriteData  out  DATA_W           data to register file
//  RegWrite   out  1                one-cycle write enable to register file
//  zero_drops out  8                saturating count of accepted writes to R0
// BEHAVIOUR
//  - State: last_grant pointer, output stage (RegWrite/WriteReg/WriteData), zero_drops.
//  - Reset (async, rst=1): RegWrite=0, WriteReg=0, WriteData=0, zero_drops=0,
//    last_grant=NUM_REQ-1 (requester 0 has first priority); req_ready=0 while rst=1.
//  - Arbitration (combinational): search from last_grant+1 upward, wrapping mod
//    NUM_REQ; first i with req_valid[i]=1 gets req_ready[i]=1. All others 0.
//  - stall=1: req_ready=0 for all; no handshake; last_grant unchanged.
//  - No valid requester: req_ready=0; last_grant unchanged.
//  - Handshake in cycle N -> at edge N+1: last_grant<=i; WriteReg<=req_reg[i];
//    WriteData<=req_data[i]; RegWrite<=(req_reg[i]!=0). Latency exactly 1 cycle.
//  - Cycle with no handshake: RegWrite<=0; WriteReg/WriteData hold last values.
//  - Back-to-back: one accept per cycle max; RegWrite may stay high consecutively.
//  - Target R0: accepted (ready=1, requester released), RegWrite stays 0,
//    zero_drops increments, saturates at 255.
//  - Two requesters targeting same register same cycle: only the RR winner is
//    accepted; loser stays valid, accepted in a later cycle -> later write wins.
//  - Requesters must hold req_reg/req_data stable while valid&!ready.
//  - Fairness: a continuously valid requester is accepted within NUM_REQ
//    non-stalled cycles.
//  - rst asserted mid-operation: in-flight write discarded, RegWrite drops
//    immediately (async), pointer returns to NUM_REQ-1.
// TESTING
//  1 Reset then req_valid=4'b0101, reg0=3 data 8'hA5, reg2=5 data 8'h3C ->
//    cycle0 ready=0001; next cycle RegWrite=1 WriteReg=3 WriteData=A5, ready=0100;
//    then WriteReg=5 WriteData=3C.
//  2 All 4 valid for 8 cycles, distinct regs 1..4 -> grant order 0,1,2,3,0,1,2,3;
//    RegWrite high 8 consecutive cycles.
//  3 Requester 1 writes reg 0 data FF three times -> ready pulses, RegWrite=0,
//    zero_drops=3; 300 R0 writes -> zero_drops=255.
//  4 stall=1 for 3 cycles with req_valid=1111 -> req_ready=0, RegWrite=0,
//    pointer unchanged; stall=0 -> next grant resumes RR order.
//  5 Requesters 0 and 2 both target reg 6 (data 11, 22) same cycle -> 0 first,
//    2 next cycle; final register-file R6=22.
//  6 rst pulse while RegWrite=1 -> RegWrite=0 same cycle; after release,
//    requester 0 wins first.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the 8x8 register file (R0 hardwired to
//   zero) between NUM_REQ writeback sources. It uses round-robin arbitration
//   with a valid/ready handshake. The granted write is registered once and
//   then driven to the register file.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester write pending
//   req_reg    : per-requester target register, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   : per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot accept; a handshake occurs on valid & ready
//   stall      : blocks new grants while the write port is unavailable
//   WriteReg   : registered register index to the register file
//   WriteData  : registered write data to the register file
//   RegWrite   : one-cycle write enable to the register file
//   zero_drops : saturating count of accepted writes that target R0
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       stall,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  output logic                       RegWrite,
  output logic [7:0]                 zero_drops
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              reg_write_q, reg_write_d;
  logic [7:0]        zero_drops_q, zero_drops_d;

  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic              handshake;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Round-robin search. The search starts one past the last winner, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is suppressed during stall and reset, so no handshake can occur then.
  always_comb begin
    req_ready = '0;
    handshake = grant_found && !stall && !rst;
    if (handshake) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Select the winner's target register and data.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the output stage and the pointer. When no handshake
  // occurs, the write enable drops and the index and data hold. A write to R0
  // is still accepted but is only counted.
  always_comb begin
    last_grant_d = last_grant_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    zero_drops_d = zero_drops_q;
    if (handshake) begin
      last_grant_d = grant_idx;
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      reg_write_d  = (sel_reg != '0);
      if (sel_reg == '0 && zero_drops_q != 8'hFF) begin
        zero_drops_d = zero_drops_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PTR_W'(NUM_REQ - 1);
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      zero_drops_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      zero_drops_q <= zero_drops_d;
    end
  end

  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign RegWrite   = reg_write_q;
  assign zero_drops = zero_drops_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed table-driven checks of the round-robin register-file write
//   arbiter. Hand-written sequences cover R0 drops, saturation and reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_reg;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        stall;
  logic [2:0]  WriteReg;
  logic [7:0]  WriteData;
  logic        RegWrite;
  logic [7:0]  zero_drops;

  int checks;
  int fails;
  logic [7:0] rf [8];

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] regs;
    logic [31:0] data;
    logic        stall;
    logic [3:0]  exp_ready;
    logic        exp_rw;
    logic [2:0]  exp_wr;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t vecs [21];

  regfile_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .stall      (stall),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .zero_drops (zero_drops)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [11:0] r,
                               input logic [31:0] d, input logic s);
    req_valid = v;
    req_reg   = r;
    req_data  = d;
    stall     = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for the active edge, sample just after it, and mirror register-file writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (RegWrite === 1'b1) rf[WriteReg] = WriteData;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // Test 1: two requesters, with requester 0 winning first after reset.
    vecs[0]  = '{4'b0101, {3'd0,3'd5,3'd0,3'd3}, 32'h003C00A5, 1'b0, 4'b0001, 1'b1, 3'd3, 8'hA5};
    vecs[1]  = '{4'b0101, {3'd0,3'd5,3'd0,3'd3}, 32'h003C00A5, 1'b0, 4'b0100, 1'b1, 3'd5, 8'h3C};
    vecs[2]  = '{4'b0000, {3'd0,3'd5,3'd0,3'd3}, 32'h003C00A5, 1'b0, 4'b0000, 1'b0, 3'd5, 8'h3C};
    // Serve requester 3 so that the pointer sits at 3 for the full rotation.
    vecs[3]  = '{4'b1000, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b0, 4'b1000, 1'b1, 3'd4, 8'h40};
    // Test 2: all four valid for 8 cycles give grant order 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      vecs[4+k] = '{4'b1111, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b0,
                    4'(1 << (k % 4)), 1'b1, 3'(k % 4 + 1), 8'((k % 4 + 1) * 16)};
    end
    // Test 4: stall holds off all grants and keeps the pointer at 3.
    for (int k = 0; k < 3; k++) begin
      vecs[12+k] = '{4'b1111, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b1, 4'b0000, 1'b0, 3'd4, 8'h40};
    end
    vecs[15] = '{4'b1111, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b0, 4'b0001, 1'b1, 3'd1, 8'h10};
    vecs[16] = '{4'b0000, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b0, 4'b0000, 1'b0, 3'd1, 8'h10};
    // Test 5: requesters 0 and 2 both target R6. The pointer is first moved to 3.
    vecs[17] = '{4'b1000, {3'd7,3'd6,3'd0,3'd6}, 32'h77220011, 1'b0, 4'b1000, 1'b1, 3'd7, 8'h77};
    vecs[18] = '{4'b0101, {3'd7,3'd6,3'd0,3'd6}, 32'h77220011, 1'b0, 4'b0001, 1'b1, 3'd6, 8'h11};
    vecs[19] = '{4'b0100, {3'd7,3'd6,3'd0,3'd6}, 32'h77220011, 1'b0, 4'b0100, 1'b1, 3'd6, 8'h22};
    vecs[20] = '{4'b0000, {3'd7,3'd6,3'd0,3'd6}, 32'h77220011, 1'b0, 4'b0000, 1'b0, 3'd6, 8'h22};

    // Reset with a requester already valid; ready must stay low.
    rst = 1'b1;
    applyStimulus(4'b0001, 12'h003, 32'h000000A5, 1'b0);
    #12;
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_regwrite", 32'(RegWrite), 32'h0);
    checkOutput("reset_writereg", 32'(WriteReg), 32'h0);
    checkOutput("reset_writedata", 32'(WriteData), 32'h0);
    checkOutput("reset_zero_drops", 32'(zero_drops), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0000, 12'h000, 32'h0, 1'b0);

    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      applyStimulus(vecs[n].valid, vecs[n].regs, vecs[n].data, vecs[n].stall);
      #1;
      checkOutput($sformatf("v%0d_ready", n), 32'(req_ready), 32'(vecs[n].exp_ready));
      tick();
      checkOutput($sformatf("v%0d_regwrite", n), 32'(RegWrite), 32'(vecs[n].exp_rw));
      checkOutput($sformatf("v%0d_writereg", n), 32'(WriteReg), 32'(vecs[n].exp_wr));
      checkOutput($sformatf("v%0d_writedata", n), 32'(WriteData), 32'(vecs[n].exp_wd));
      checkOutput($sformatf("v%0d_zero_drops", n), 32'(zero_drops), 32'h0);
    end
    checkOutput("rf_r6_later_write_wins", 32'(rf[6]), 32'h22);

    // Test 3: requester 1 writes R0 three times; each write is accepted and dropped.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      applyStimulus(4'b0010, 12'h000, 32'h0000FF00, 1'b0);
      #1;
      checkOutput($sformatf("r0_%0d_ready", k), 32'(req_ready), 32'h2);
      tick();
      checkOutput($sformatf("r0_%0d_regwrite", k), 32'(RegWrite), 32'h0);
      checkOutput($sformatf("r0_%0d_zero_drops", k), 32'(zero_drops), 32'(k));
    end
    // Run 300 more R0 writes; the count must saturate at 255.
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 251) checkOutput("r0_reach_255", 32'(zero_drops), 32'hFF);
    end
    checkOutput("r0_saturated", 32'(zero_drops), 32'hFF);
    checkOutput("r0_sat_regwrite", 32'(RegWrite), 32'h0);

    // Test 6: reset pulse while a write is being presented.
    @(negedge clk);
    applyStimulus(4'b0001, 12'h005, 32'h00000055, 1'b0);
    #1;
    checkOutput("rst_pre_ready", 32'(req_ready), 32'h1);
    tick();
    checkOutput("rst_pre_regwrite", 32'(RegWrite), 32'h1);
    checkOutput("rst_pre_writereg", 32'(WriteReg), 32'h5);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_regwrite", 32'(RegWrite), 32'h0);
    checkOutput("rst_async_writereg", 32'(WriteReg), 32'h0);
    checkOutput("rst_async_writedata", 32'(WriteData), 32'h0);
    checkOutput("rst_async_zero_drops", 32'(zero_drops), 32'h0);
    checkOutput("rst_async_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, {3'd4,3'd3,3'd2,3'd1}, 32'h40302010, 1'b0);
    #1;
    checkOutput("rst_post_ready", 32'(req_ready), 32'h1);
    tick();
    checkOutput("rst_post_regwrite", 32'(RegWrite), 32'h1);
    checkOutput("rst_post_writereg", 32'(WriteReg), 32'h1);
    checkOutput("rst_post_writedata", 32'(WriteData), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
